// File: rtl/speed_tick_gen.sv
// speed_tick_gen: variable-rate game tick generator.
// A free-running counter defines a period of 2^(SLOW_BIT+1-level) enabled
// cycles. Each wrap emits a one-cycle tick, bumps a 16-bit tick counter and
// is the only moment a pending level request may take effect. Because of
// that, a period is never cut short and game_clk never glitches.

module speed_tick_gen #(
    parameter int SLOW_BIT = 24,
    parameter int LEVELS   = 4,
    parameter int LW       = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          speed_up,
    input  logic          slow_down,
    input  logic          level_load,
    input  logic [LW-1:0] level_in,
    output logic          tick,
    output logic          game_clk,
    output logic [LW-1:0] level,
    output logic          level_max,
    output logic [15:0]   tick_count
);

    localparam int            CW      = SLOW_BIT + 1;
    localparam logic [LW-1:0] MAX_LVL = LW'(LEVELS - 1);

    // Reject parameter sets that would let the period collapse below 2 cycles
    // or leave the level ports too narrow to hold the top level.
    if (LEVELS < 2 || LEVELS > 8 || SLOW_BIT < LEVELS - 1 || LW < $clog2(LEVELS)) begin : g_param_check
        $error("speed_tick_gen: illegal SLOW_BIT/LEVELS/LW combination");
    end

    typedef enum logic {
        PAUSE = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t        state_q;

    logic [CW-1:0] cnt_q,   cnt_d;
    logic [LW-1:0] lvl_q,   lvl_d;
    logic [LW-1:0] pend_q,  pend_d;
    logic          tick_q,  tick_d;
    logic          gclk_q,  gclk_d;
    logic [15:0]   tcnt_q,  tcnt_d;

    logic [CW-1:0] last_cnt;
    logic [CW-1:0] half_cnt;
    logic          wrap;

    // Period decode: last count of the current period, its half-way bit, and the wrap strobe.
    always_comb begin
        last_cnt = {CW{1'b1}} >> lvl_q;
        half_cnt = (last_cnt >> 1) + CW'(1);
        wrap     = enable && (cnt_q == last_cnt);
    end

    // Pending level: load has priority, then a lone speed_up or slow_down with saturation.
    always_comb begin
        pend_d = pend_q;
        if (level_load) begin
            pend_d = (level_in > MAX_LVL) ? MAX_LVL : level_in;
        end else if (speed_up && !slow_down) begin
            if (pend_q != MAX_LVL) begin
                pend_d = pend_q + LW'(1);
            end
        end else if (slow_down && !speed_up) begin
            if (pend_q != '0) begin
                pend_d = pend_q - LW'(1);
            end
        end
    end

    // Counter, tick, game_clk and level update. Everything holds while enable is low.
    // The level takes the pending value as it stood before this cycle's request,
    // so a request that lands on a wrap waits for the following wrap.
    always_comb begin
        cnt_d  = cnt_q;
        lvl_d  = lvl_q;
        tick_d = 1'b0;
        gclk_d = gclk_q;
        tcnt_d = tcnt_q;
        if (enable) begin
            gclk_d = |(cnt_q & half_cnt);
            if (wrap) begin
                cnt_d  = '0;
                lvl_d  = pend_q;
                tick_d = 1'b1;
                tcnt_d = tcnt_q + 16'd1;
            end else begin
                cnt_d  = cnt_q + CW'(1);
            end
        end
    end

    // State registers; reset discards partial counts and any pending request at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            lvl_q  <= '0;
            pend_q <= '0;
            tick_q <= 1'b0;
            gclk_q <= 1'b0;
            tcnt_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            lvl_q  <= lvl_d;
            pend_q <= pend_d;
            tick_q <= tick_d;
            gclk_q <= gclk_d;
            tcnt_q <= tcnt_d;
        end
    end

    // RUN/PAUSE run-state, following enable one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PAUSE;
        end else begin
            case (state_q)
                RUN:     if (!enable) state_q <= PAUSE;
                PAUSE:   if (enable)  state_q <= RUN;
                default: state_q <= PAUSE;
            endcase
        end
    end

    assign tick       = tick_q;
    assign game_clk   = gclk_q;
    assign level      = lvl_q;
    assign level_max  = (lvl_q == MAX_LVL);
    assign tick_count = tcnt_q;

endmodule

// File: tb/tb_speed_tick_gen.sv
// Testbench for speed_tick_gen (SLOW_BIT=3, LEVELS=4: periods 16/8/4/2).
// A reference model tracks the position within the current period, the
// applied and pending levels, and the tick total. Every cycle, the DUT outputs
// are compared against this model.

module tb_speed_tick_gen;

    localparam int SB  = 3;
    localparam int LV  = 4;
    localparam int LWP = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           enable = 1'b0;
    logic           speed_up = 1'b0;
    logic           slow_down = 1'b0;
    logic           level_load = 1'b0;
    logic [LWP-1:0] level_in = '0;
    logic           tick;
    logic           game_clk;
    logic [LWP-1:0] level;
    logic           level_max;
    logic [15:0]    tick_count;

    always #5 clk = ~clk;

    speed_tick_gen #(.SLOW_BIT(SB), .LEVELS(LV), .LW(LWP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .speed_up   (speed_up),
        .slow_down  (slow_down),
        .level_load (level_load),
        .level_in   (level_in),
        .tick       (tick),
        .game_clk   (game_clk),
        .level      (level),
        .level_max  (level_max),
        .tick_count (tick_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int m_phase;   // enabled cycles elapsed in the current period
    int m_lvl;     // applied level
    int m_pend;    // pending level
    int m_tc;      // ticks since reset
    int m_tick;
    int m_gclk;

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int per(input int l);
        return 1 << (SB + 1 - l);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_lvl = 0; m_pend = 0; m_tc = 0; m_tick = 0; m_gclk = 0;
    endtask

    // One rising edge with the given inputs.
    task automatic model_edge(input bit en, input bit su, input bit sd, input bit ll, input int li);
        int np;
        np = m_pend;
        if (ll)             np = (li > LV - 1) ? LV - 1 : li;
        else if (su && !sd) np = (m_pend + 1 > LV - 1) ? LV - 1 : m_pend + 1;
        else if (sd && !su) np = (m_pend - 1 < 0) ? 0 : m_pend - 1;
        m_tick = 0;
        if (en) begin
            // square wave: high during the second half of the period (one cycle late)
            m_gclk = (m_phase >= per(m_lvl) / 2) ? 1 : 0;
            if (m_phase == per(m_lvl) - 1) begin
                m_phase = 0;
                m_tick  = 1;
                m_tc    = (m_tc + 1) % 65536;
                m_lvl   = m_pend;
            end else begin
                m_phase++;
            end
        end
        m_pend = np;
    endtask

    task automatic check_outputs();
        chk("tick",       tick,       m_tick);
        chk("game_clk",   game_clk,   m_gclk);
        chk("level",      level,      m_lvl);
        chk("level_max",  level_max,  (m_lvl == LV - 1) ? 1 : 0);
        chk("tick_count", tick_count, m_tc);
    endtask

    // Called just after a rising edge: drive inputs, take one edge, check.
    task automatic step(input bit en, input bit su, input bit sd, input bit ll, input int li);
        enable     = en;
        speed_up   = su;
        slow_down  = sd;
        level_load = ll;
        level_in   = LWP'(li);
        @(posedge clk);
        model_edge(en, su, sd, ll, li);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
    endtask

    task automatic run_to_tick(input int limit, output int n);
        bit got;
        got = 0;
        n   = 0;
        while (!got && n < limit) begin
            step(1, 0, 0, 0, 0);
            n++;
            if (tick) got = 1;
        end
        if (!got) chk("tick_timeout", 0, 1);
    endtask

    // Mid-period asynchronous reset pulse, held across one rising edge.
    task automatic do_reset();
        #2;
        rst_n      = 1'b0;
        speed_up   = 1'b0;
        slow_down  = 1'b0;
        level_load = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;
    endtask

    initial begin
        int first;
        int n;
        int k;
        int tc_hold;

        // reset values
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        check_outputs();

        // release with enable held: 16-cycle period, tick on the 16th edge
        enable = 1'b1;
        rst_n  = 1'b1;
        first  = -1;
        for (int i = 1; i <= 48; i++) begin
            step(1, 0, 0, 0, 0);
            if (tick && first < 0) first = i;
        end
        chk("first_tick_edge", first, 16);
        chk("tc_after_48", tick_count, 3);

        // speed_up mid-period: current 16-cycle period completes, then 8
        idle(5);
        step(1, 1, 0, 0, 0);
        chk("lvl_before_wrap", level, 0);
        run_to_tick(40, n);
        chk("period_l0_completes", n + 6, 16);
        chk("lvl_after_wrap", level, 1);
        run_to_tick(40, n);
        chk("period_l1", n, 8);

        // saturation at the top level, then simultaneous up/down
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 0, 0, 0);
            step(1, 0, 0, 0, 0);
        end
        idle(40);
        chk("lvl_saturated", level, 3);
        chk("level_max_hi", level_max, 1);
        run_to_tick(10, n);
        run_to_tick(10, n);
        chk("period_l3", n, 2);
        step(1, 1, 1, 0, 0);
        idle(10);
        chk("both_no_change", level, 3);

        // load beats slow_down, then pause freezes everything
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        idle(10);
        chk("lvl_down_to_1", level, 1);
        step(1, 0, 1, 1, 7);
        tc_hold = m_tc;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 0, 0);
            chk("pause_no_tick", tick, 0);
        end
        chk("pause_tc_frozen", tick_count, tc_hold);
        run_to_tick(20, n);
        chk("load_applied", level, 3);

        // request in the exact wrap cycle applies one wrap later
        step(1, 0, 0, 1, 0);
        run_to_tick(20, n);
        chk("lvl_loaded_0", level, 0);
        k = 0;
        while (m_phase != per(m_lvl) - 1 && k < 40) begin
            step(1, 0, 0, 0, 0);
            k++;
        end
        step(1, 1, 0, 0, 0);
        chk("tick_at_wrap_req", tick, 1);
        chk("lvl_at_wrap_req", level, 0);
        run_to_tick(40, n);
        chk("period_after_wrap_req", n, 16);
        chk("lvl_next_wrap", level, 1);

        // reset mid-period drops a pending request
        idle(3);
        step(1, 1, 0, 0, 0);
        do_reset();
        chk("rst_level", level, 0);
        run_to_tick(40, n);
        chk("rst_restart_period", n, 16);
        chk("rst_pending_lost", level, 0);

        // randomized traffic with occasional pauses, loads and resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) != 0,
                     $urandom_range(0, 15) == 0,
                     $urandom_range(0, 15) == 0,
                     $urandom_range(0, 31) == 0,
                     int'($urandom_range(0, 7)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/speed_tick_gen.md
SPEED_TICK_GEN -- requirements
Module: speed_tick_gen

Interface
REQ-001 Parameter SLOW_BIT, default 24, counter bit index that sets the level-0 period of 2^(SLOW_BIT+1) cycles.
REQ-002 Parameter LEVELS, default 4, number of speed levels; legal range 2..8, and SLOW_BIT SHALL be >= LEVELS-1 (elaboration error otherwise).
REQ-003 Parameter LW, default 3, width of level ports; SHALL be >= clog2(LEVELS).
REQ-004 clk  in  1  system clock; all state SHALL change on its rising edge only.
REQ-005 rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 enable  in  1  1 = run, 0 = pause.
REQ-007 speed_up  in  1  single-cycle request to raise the level by 1.
REQ-008 slow_down  in  1  single-cycle request to lower the level by 1.
REQ-009 level_load  in  1  single-cycle request to load level_in.
REQ-010 level_in  in  LW  requested level for level_load.
REQ-011 tick  out  1  one-cycle pulse, once per period.
REQ-012 game_clk  out  1  registered square wave at the current period (50% duty).
REQ-013 level  out  LW  currently applied level.
REQ-014 level_max  out  1  high when level == LEVELS-1.
REQ-015 tick_count  out  16  ticks since reset; wraps from 0xFFFF to 0.

Function
REQ-016 Applied level L SHALL set period P(L) = 2^(SLOW_BIT+1-L) enabled cycles.
REQ-017 The internal counter cnt, SLOW_BIT+1 bits, SHALL increment by 1 on each cycle with enable=1 and hold on each cycle with enable=0.
REQ-018 When enable=1 and cnt == P(L)-1, cnt SHALL become 0 and tick SHALL be 1 on the following cycle; tick SHALL be 0 at all other times.
REQ-019 game_clk SHALL be the registered value of cnt[SLOW_BIT-L], lagging cnt by one cycle.
REQ-020 The FSM SHALL have two states: RUN (enable=1) and PAUSE (enable=0); the state SHALL follow enable with a one-cycle registration.
REQ-021 In PAUSE, cnt, game_clk and tick_count SHALL hold, tick SHALL be 0, and level requests SHALL still be accepted into pending.
REQ-022 Requests SHALL update a pending level PL (starting from PL, not L), with priority level_load > speed_up/slow_down.
REQ-023 level_load SHALL set PL = min(level_in, LEVELS-1).
REQ-024 speed_up alone SHALL set PL = min(PL+1, LEVELS-1); slow_down alone SHALL set PL = max(PL-1, 0); both together SHALL leave PL unchanged.
REQ-025 A pending change SHALL be applied (L := PL) only in the cycle cnt wraps to 0, so no period is truncated and game_clk never glitches.
REQ-026 A request arriving in the same cycle as a wrap SHALL apply at the next wrap, not the current one.
REQ-027 tick_count SHALL increment by 1 in the same cycle that tick is asserted.

Reset
REQ-028 While rst_n=0: cnt=0, L=PL=0, tick=0, game_clk=0, tick_count=0, state=PAUSE, level_max=0.
REQ-029 Reset asserted mid-period SHALL discard pending requests and partial counts immediately; counting SHALL restart from 0 on the first enabled edge after release.

Verification (SLOW_BIT=3, LEVELS=4, so P = 16/8/4/2)
REQ-030 Release reset with enable=1 held -> first tick on cycle 17 after release, then every 16 cycles; game_clk is 8 cycles low then 8 cycles high; tick_count = 3 after 48 cycles.
REQ-031 Pulse speed_up mid-period at level 0 -> current 16-cycle period completes, then period becomes 8; level=1 from the wrap cycle.
REQ-032 Pulse speed_up 5 times -> level saturates at 3, level_max=1, period 2; then pulse speed_up and slow_down together -> no change.
REQ-033 Pulse level_load with level_in=7 together with slow_down -> load wins, PL=3; drop enable for 20 cycles -> no tick, and cnt, game_clk and tick_count frozen; re-enable -> count resumes where it stopped.
REQ-034 Pulse speed_up in the exact wrap cycle -> change applies at the following wrap.
REQ-035 Assert rst_n=0 for 1 cycle mid-period with a pending change -> all outputs are at reset values immediately, and the pending change is lost.
